freq_gen_multi: RTL
===================

# freq_gen_multi

Synthesizable, parametrised successor to the fixed-rate behavioural clock source. It derives NUM_CH independent square-wave outputs from one system clock, and each channel has a runtime-programmable integer divisor. Divisor changes are glitch-free because each new value takes effect only at a period boundary. The block sits beside the system clock root and feeds low-rate strobes and test clocks to peripheral logic.

## Interface
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 16, divisor width in bits
- DEF_DIV, 40, divisor loaded at reset (100 MHz in gives 2.5 MHz out)
- clock  input  1  system clock; all logic is on its rising edge
- reset_n  input  1  reset, asynchronous and active-low
- en_i  input  NUM_CH  per-channel enable, level-sensitive
- cfg_valid_i  input  1  divisor write request
- cfg_ch_i  input  $clog2(NUM_CH) (minimum 1)  target channel
- cfg_div_i  input  DIV_W  requested divisor N
- cfg_ready_o  output  1  write can be accepted (combinational)
- cfg_err_o  output  1  one-cycle pulse when a write is rejected
- clk_o  output  NUM_CH  generated square waves, registered
- tick_o  output  NUM_CH  one-cycle pulse, registered, coincident with each rising edge of clk_o

## Operation
- Each channel holds three items: active divisor A, shadow divisor S with a pending flag P, and counter cnt (DIV_W bits).
- Output period is A clock cycles.
  - High for H = A − (A>>1) cycles (ceil).
  - Low for A>>1 cycles (floor).
  - clk_o <= (cnt_next < H).
- Handshake:
  - cfg_ready_o = ~P[cfg_ch_i].
  - A write is accepted on a clock edge where cfg_valid_i && cfg_ready_o.
  - When cfg_div_i < 2 or cfg_ch_i ≥ NUM_CH, the write is accepted but discarded, and cfg_err_o pulses on the next cycle.
  - A valid write loads S and sets P.
- Boundary: the edge where cnt wraps from A−1 to 0.
  - If P=1, A <= S and P <= 0.
  - The new period starts immediately.
- Disabled channel (en_i=0):
  - cnt=0, clk_o=0, tick_o=0.
  - A pending write is applied on the next edge, not at a boundary.
- Priority per channel: reset > disable > sync (when compiled in) > boundary load > count.
- Simultaneous events:
  - Accept on the same edge as that channel's boundary: the value is applied at the following boundary.
  - Accept on the same edge as en_i falling: the value is applied on the next edge.
- Arithmetic:
  - cnt compares against A−1 at full DIV_W width; no overflow is possible.
  - A = 2^DIV_W − 1 is legal.

## Timing
- Reset values:
  - clk_o=0, tick_o=0, cfg_err_o=0.
  - cnt=0, P=0.
  - A=S=DEF_DIV.
  - cfg_ready_o=1.
- Enable latency: en_i sampled high on edge k (after being low) gives cnt=0, clk_o=1 and tick_o=1 after edge k.
- Disable latency: en_i sampled low on edge k gives clk_o=0 after edge k. Stopping mid-period truncates the high or low phase.
- Write latency: accept on edge k sets P; cfg_ready_o for that channel goes low after edge k and returns high after the applying edge.
- When reset_n is asserted mid-period, all outputs clear asynchronously. The first rising edge after release follows the enable latency above.
- Divisor 2 gives clk_o toggling every cycle, with tick_o pulsing every second cycle.

## Configuration
- FREQ_GEN_SYNC_EN adds the input port sync_i (1 bit).
  - When sync_i is sampled high, every enabled channel forces cnt=0 and clk_o=1, pulses tick_o, and applies any pending write.
  - This phase-aligns all channels.
- Without the macro, the port is absent and channels free-run independently.

## Structure
- Package freq_gen_pkg holds:
  - MIN_DIV = 2;
  - function hi_len(N) = N − (N>>1);
  - localparam for channel-index width.
- Sub-module freq_gen_ch contains one channel (A, S, P, cnt, clk_o and tick_o registers) and is instantiated NUM_CH times with a generate loop.
- The top level decodes the write, drives cfg_ready_o and cfg_err_o, and fans out sync_i.

## Test plan
- Reset, then en_i=4'b0001 with DEF_DIV=40 -> clk_o[0] high 20 cycles and low 20 cycles; tick_o[0] every 40 cycles; first high one cycle after enable.
- Odd divisor: write ch1 N=5, enable -> clk_o[1] high 3 and low 2; period 5.
- Mid-period write: ch0 running N=40, write N=10 at cnt=7 -> old period completes at 40; next period is 10; cfg_ready_o low in between; a second write during pending is blocked.
- Invalid writes: N=1 or ch=NUM_CH -> cfg_err_o pulse next cycle; no change to A or P.
- Disable at cnt=3 of a high phase -> clk_o=0 next cycle. Re-enable -> restart with a full high phase; a pending write applies immediately while disabled.
- FREQ_GEN_SYNC_EN: ch0 N=4 and ch1 N=6 running, sync_i pulse -> both rise on the same cycle; tick_o coincident on both; rising edges coincide again every 12 cycles.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// Shared constants and helpers for the multi-channel divided-clock generator.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package freq_gen_pkg;

  // Smallest divisor that still yields a square wave (one high, one low cycle).
  localparam int MIN_DIV = 2;

  // Largest supported channel count and the index width it needs.
  localparam int MAX_CH   = 16;
  localparam int CH_W_MAX = 4;

  // Channel-index width for a given channel count, never narrower than 1 bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // High-phase length of a period of n cycles: the odd cycle goes to the high phase.
  function automatic int unsigned hi_len(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/freq_gen_multi_if.sv
// Divisor-write channel: request (valid/channel/divisor), ready and error pulse.
// Latency: ready is combinational; error pulses one cycle after a rejected write.
// Backpressure: ready is low while the addressed channel holds an unapplied write.
interface freq_gen_multi_if
  import freq_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic              cfg_valid_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [DIV_W-1:0]  cfg_div_i;
  logic              cfg_ready_o;
  logic              cfg_err_o;

  modport master (
    output cfg_valid_i, cfg_ch_i, cfg_div_i,
    input  cfg_ready_o, cfg_err_o
  );

  modport slave (
    input  cfg_valid_i, cfg_ch_i, cfg_div_i,
    output cfg_ready_o, cfg_err_o
  );
endinterface

// File: rtl/freq_gen_ch.sv
// One divided-clock channel: active/shadow divisor, pending flag, period counter.
// Latency: clk_o/tick_o registered; enable or sync starts a high phase after one edge.
// Backpressure: pend stays high from an accepted write until the edge that applies it.
module freq_gen_ch
  import freq_gen_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend,
  output logic             clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] a_q, a_d, s_q, s_d, cnt_q, cnt_d, hi;
  logic             p_q, p_d, run_q, clk_d, tick_d;

  assign hi   = DIV_W'(hi_len(32'(a_q)));
  assign pend = p_q;

  // Next-state: disable, then sync or (re)start, then period wrap, else count.
  always_comb begin
    a_d    = a_q;
    s_d    = s_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (!en) begin
      // Stopped: nothing to stay glitch-free for, so a pending divisor lands now.
      cnt_d = '0;
      if (p_q) begin
        a_d = s_q;
        p_d = 1'b0;
      end
    end else if (sync || !run_q || (cnt_q >= a_q - DIV_W'(1))) begin
      // Period start; every divisor is at least 2, so the first cycle is high.
      cnt_d  = '0;
      clk_d  = 1'b1;
      tick_d = 1'b1;
      if (p_q) begin
        a_d = s_q;
        p_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      clk_d = (cnt_d < hi);
    end
    // Writes are only accepted while nothing is pending, so this never masks a load.
    if (wr) begin
      s_d = wr_div;
      p_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= DIV_W'(DEF_DIV);
      s_q    <= DIV_W'(DEF_DIV);
      p_q    <= 1'b0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      a_q    <= a_d;
      s_q    <= s_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      run_q  <= en;
      clk_o  <= clk_d;
      tick_o <= tick_d;
    end
  end

endmodule

// File: rtl/freq_gen_multi.sv
// NUM_CH independent square waves from one clock, divisors retimed to period boundaries.
// Latency: outputs registered; rejected-write error pulses the cycle after the accept edge.
// Backpressure: cfg_ready_o low while the addressed channel has a pending write; FREQ_GEN_SYNC_EN adds sync_i.
module freq_gen_multi
  import freq_gen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 40
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef FREQ_GEN_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic [NUM_CH-1:0] en_i,
  freq_gen_multi_if.slave   cfg,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0]      pend;
  logic [NUM_CH-1:0]      wr;
  logic [(2**CH_W)-1:0]   pend_pad;
  logic                   accept, bad, err_q, sync;

`ifdef FREQ_GEN_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // Unused channel indices read as never-pending so out-of-range writes get accepted and flagged.
  always_comb begin
    pend_pad             = '0;
    pend_pad[NUM_CH-1:0] = pend;
  end

  assign cfg.cfg_ready_o = ~pend_pad[cfg.cfg_ch_i];
  assign accept          = cfg.cfg_valid_i & cfg.cfg_ready_o;
  assign bad             = (cfg.cfg_div_i < DIV_W'(MIN_DIV)) || (32'(cfg.cfg_ch_i) >= NUM_CH);
  assign cfg.cfg_err_o   = err_q;

  // Decode an accepted, legal write to its channel.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = accept && !bad && (cfg.cfg_ch_i == CH_W'(i));
    end
  end

  // One-cycle error pulse for writes that were accepted but discarded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= accept & bad;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_gen_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (en_i[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg.cfg_div_i),
      .pend    (pend[g]),
      .clk_o   (clk_o[g]),
      .tick_o  (tick_o[g])
    );
  end

endmodule
